// File: rtl/dbus_mmio_bridge.sv
// dbus_mmio_bridge: splits the CPU data port between the data RAM and a
// small MMIO block (LED, switches, 32-bit timer with compare interrupt).
//
// Ports:
//   cpu_clk_50M, cpu_rst        clock, synchronous active-high reset
//   daddr, dce, we, din, dm     CPU data port (dm valid one cycle later)
//   ram_addr/ce/we/din/dout     synchronous data RAM (1-cycle read)
//   sw, led                     board switches in, LED register out
//   timer_irq                   level interrupt = pending & irq_en
//
// Optional build macro: TIMER_PRESCALE_EN adds a PRESCALE register at
// offset 0x14 that divides the timer advance rate by (PRESCALE + 1).

module dbus_mmio_bridge #(
    parameter logic [15:0] MMIO_BASE = 16'hBFAF,
    parameter int          LED_W     = 16,
    parameter int          SW_W      = 16
) (
    input  logic             cpu_clk_50M,
    input  logic             cpu_rst,
    input  logic [31:0]      daddr,
    input  logic             dce,
    input  logic [3:0]       we,
    input  logic [31:0]      din,
    output logic [31:0]      dm,
    output logic [31:0]      ram_addr,
    output logic             ram_ce,
    output logic [3:0]       ram_we,
    output logic [31:0]      ram_din,
    input  logic [31:0]      ram_dout,
    input  logic [SW_W-1:0]  sw,
    output logic [LED_W-1:0] led,
    output logic             timer_irq
);

    // Byte-lane merge of a CPU write into an existing register value.
    function automatic logic [31:0] f_merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  be
    );
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return r;
    endfunction

    logic [LED_W-1:0] r_led;
    logic [SW_W-1:0]  r_sw_q;
    logic [31:0]      r_count;
    logic [31:0]      r_cmp;
    logic             r_en;
    logic             r_pend;
    logic             r_reload;
    logic             r_irqen;
    logic             r_sel;
    logic [31:0]      r_rdata;

    logic             w_is_mmio;
    logic [13:0]      w_off;
    logic             w_wr;
    logic             w_rd;
    logic             w_wr_led;
    logic             w_wr_cnt;
    logic             w_wr_cmp;
    logic             w_wr_ctrl;
    logic             w_w1c;
    logic             w_tick;
    logic             w_match;
    logic [31:0]      w_cnt_inc;
    logic [31:0]      w_cnt_base;
    logic [31:0]      w_cnt_tmr;
    logic [31:0]      w_rdata;
    logic [LED_W-1:0] w_led_next;

    assign w_is_mmio = dce & (daddr[31:16] == MMIO_BASE);
    assign w_off     = daddr[15:2];
    assign w_wr      = w_is_mmio & (|we);
    assign w_rd      = dce & (we == 4'b0000);
    assign w_wr_led  = w_wr & (w_off == 14'h0);
    assign w_wr_cnt  = w_wr & (w_off == 14'h2);
    assign w_wr_cmp  = w_wr & (w_off == 14'h3);
    assign w_wr_ctrl = w_wr & (w_off == 14'h4);
    assign w_w1c     = w_wr_ctrl & we[0] & din[1];

    assign ram_ce   = dce & ~w_is_mmio;
    assign ram_we   = ram_ce ? we : 4'b0000;
    assign ram_addr = daddr;
    assign ram_din  = din;

    // Match is only evaluated on advance cycles; reload applies on match.
    assign w_match    = w_tick & (r_count == r_cmp);
    assign w_cnt_inc  = r_count + 32'd1;
    assign w_cnt_base = w_tick ? w_cnt_inc : r_count;
    assign w_cnt_tmr  = (w_match & r_reload) ? 32'd0 : w_cnt_base;
    assign w_led_next = LED_W'(f_merge(32'(r_led), din, we));

`ifdef TIMER_PRESCALE_EN
    logic [15:0] r_psc;
    logic [15:0] r_pcnt;
    logic        w_wr_psc;

    assign w_wr_psc = w_wr & (w_off == 14'h5);
    assign w_tick   = r_en & (r_pcnt == r_psc);

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            r_psc  <= '0;
            r_pcnt <= '0;
        end else begin
            if (w_wr_psc) r_psc <= 16'(f_merge(32'(r_psc), din, we));
            if (!r_en || w_wr_psc || w_tick) r_pcnt <= '0;
            else                             r_pcnt <= r_pcnt + 16'd1;
        end
    end
`else
    assign w_tick = r_en;
`endif

    always_comb begin
        w_rdata = '0;
        case (w_off)
            14'h0:   w_rdata = 32'(r_led);
            14'h1:   w_rdata = 32'(r_sw_q);
            14'h2:   w_rdata = r_count;
            14'h3:   w_rdata = r_cmp;
            14'h4:   w_rdata = {28'd0, r_irqen, r_reload, r_pend, r_en};
`ifdef TIMER_PRESCALE_EN
            14'h5:   w_rdata = 32'(r_psc);
`endif
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            r_led    <= '0;
            r_sw_q   <= '0;
            r_count  <= '0;
            r_cmp    <= 32'hFFFF_FFFF;
            r_en     <= 1'b0;
            r_pend   <= 1'b0;
            r_reload <= 1'b0;
            r_irqen  <= 1'b0;
            r_sel    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_sw_q <= sw;
            if (w_rd) begin
                r_sel   <= w_is_mmio;
                r_rdata <= w_rdata;
            end
            if (w_wr_led) r_led <= w_led_next;
            if (w_wr_cmp) r_cmp <= f_merge(r_cmp, din, we);
            // CPU write wins per lane; other lanes keep the increment.
            if (w_wr_cnt) r_count <= f_merge(w_cnt_base, din, we);
            else          r_count <= w_cnt_tmr;
            if (w_wr_ctrl & we[0]) begin
                r_en     <= din[0];
                r_reload <= din[2];
                r_irqen  <= din[3];
            end
            // A same-cycle match beats the write-1-to-clear.
            r_pend <= w_match | (r_pend & ~w_w1c);
        end
    end

    assign dm        = r_sel ? r_rdata : ram_dout;
    assign led       = r_led;
    assign timer_irq = r_pend & r_irqen;

endmodule
